obi_apb_splitter: RTL
=====================

# obi_apb_splitter

Parametrised OBI-to-APB peripheral splitter: one OBI target port fans out to `NUM_TARGETS` APB4 completers in a contiguous, equal-sized address window. Each APB slot has a runtime enable bit and an APB access timeout. Unmapped, disabled and timed-out accesses get an OBI error response. The block sits between the system OBI interconnect and the subsystem APB slots, and is the generalised replacement for the fixed five-port OBI/APB splitter.

## Interface
Parameters:
- `NUM_TARGETS`, 5: number of APB completers, 1..16.
- `OBI_AW` / `OBI_DW` / `OBI_IDW`, 32 / 32 / 1: OBI address, data and ID widths. `APB_AW = OBI_AW`, `APB_DW = OBI_DW`.
- `ADDR_BASE`, 32'h0105_0000: window base; must be `SS_SIZE`-aligned.
- `SS_SIZE`, 32'h1000: per-target slot size; power of two.
- `TIMEOUT_CYCLES`, 255: ACCESS-phase cycle limit. 0 disables the timeout.

Ports (one clock; `reset_n` is asynchronous, active-low):
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous active-low reset
- `obi_req`  in  1  request
- `obi_gnt`  out  1  grant
- `obi_gntpar`  out  1  equals ~obi_gnt
- `obi_addr`  in  OBI_AW  address
- `obi_we`  in  1  write enable
- `obi_be`  in  OBI_DW/8  byte enables
- `obi_wdata`  in  OBI_DW  write data
- `obi_aid`  in  OBI_IDW  transaction ID
- `obi_rvalid`  out  1  response valid
- `obi_rvalidpar`  out  1  equals ~obi_rvalid
- `obi_rready`  in  1  response ready
- `obi_rdata`  out  OBI_DW  read data
- `obi_rid`  out  OBI_IDW  echoed ID
- `obi_err`  out  1  error response
- `ss_ctrl_icn`  in  NUM_TARGETS  per-target enable; bit i enables slot i
- `apb_psel`  out  NUM_TARGETS  one-hot select
- `apb_penable`, `apb_pwrite`  out  1  shared by all slots
- `apb_paddr`  out  APB_AW  shared; full OBI address
- `apb_pwdata`  out  APB_DW  shared
- `apb_pstrb`  out  APB_DW/8  shared
- `apb_prdata`  in  NUM_TARGETS*APB_DW  slot i at bits [i*APB_DW +: APB_DW]
- `apb_pready`, `apb_pslverr`  in  NUM_TARGETS  per-slot

## Operation
- Decode: `hit = obi_addr >= ADDR_BASE && (obi_addr-ADDR_BASE)/SS_SIZE < NUM_TARGETS`. `idx = (obi_addr-ADDR_BASE)/SS_SIZE`, so slot 0 is at `ADDR_BASE`.
- FSM states IDLE, SETUP, ACCESS, RESP. At most one outstanding transaction.
- IDLE:
  - `obi_gnt = obi_req`, combinational.
  - On handshake, register `addr`, `we`, `be`, `wdata`, `aid`, `idx`, and `ok = hit && ss_ctrl_icn[idx]`.
  - If `ok`, go to SETUP. Otherwise go to RESP with `err=1`, `rdata=0`, and no APB activity.
- SETUP: `apb_psel[idx]=1`, `penable=0`. Go to ACCESS after one cycle.
- ACCESS:
  - `psel` and `penable` are 1. A timeout counter increments each cycle.
  - On `apb_pready[idx]`: capture `prdata` slice (reads only; 0 on writes) and `err = pslverr[idx]`, then go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES` (non-zero) without pready: go to RESP with `err=1`, `rdata=0`. `psel` deasserts on the transition.
- RESP: `obi_rvalid=1`; `rdata`, `err` and `rid` stay stable until `obi_rready`. Go to IDLE on `rvalid && rready`. `gnt=0` in this state.
- `apb_pstrb = be` on writes and 0 on reads. `pwrite`, `paddr` and `pwdata` are held from SETUP through the end of ACCESS. They are registered and hold their last value in other states.
- `ss_ctrl_icn` is sampled only at grant. A change during a transaction does not abort it.

## Timing
- Reset values:
  - state IDLE; all `psel`, `penable`, `pwrite` = 0.
  - `paddr`, `pwdata`, `pstrb` = 0.
  - `obi_rvalid`, `obi_err`, `obi_rdata`, `obi_rid` = 0.
  - `obi_gntpar` = 1, `obi_rvalidpar` = 1.
- Reset asserted mid-transaction: `psel` and `penable` clear immediately (asynchronously). The pending response is discarded.
- Latency (grant in cycle 0):
  - SETUP in cycle 1, ACCESS in cycle 2.
  - With zero-wait pready, `rvalid` in cycle 3. Each wait state adds 1.
  - A decode or disable error gives `rvalid` in cycle 1.
  - A timeout gives `rvalid` in cycle 2+`TIMEOUT_CYCLES`.
- Back-to-back: the earliest next grant is the cycle after the `rvalid && rready` handshake.
- All outputs except `obi_gnt` and `obi_gntpar` are registered.

## Test plan
- Read from slot 2 at 0x0105_2004, slot 2 enabled, pready in first ACCESS cycle, prdata = 0xA5A5_1234 -> `psel=3'b100` one-hot for 2 cycles, `rvalid` at cycle 3, `rdata=0xA5A5_1234`, `err=0`, `rid=aid`.
- Write to slot 0 with `be=4'b0011` and 3 wait states -> `pstrb=4'b0011`, `pwrite=1`, `pwdata` stable through ACCESS, `rvalid` at cycle 6, `err=0`.
- Accesses to 0x0105_5000 (out of window, N=5) and to slot 4 with `ss_ctrl_icn[4]=0` -> no `psel`, `rvalid` at cycle 1, `err=1`, `rdata=0`.
- `TIMEOUT_CYCLES=4`, pready held low -> `psel` drops, `err=1` at cycle 6. A following access to another slot completes normally.
- `pslverr=1` with pready, and `rready` held low for 5 cycles -> `err=1`, `rvalid` and `rdata` stable, no grant until the handshake.
- `reset_n` pulsed during ACCESS -> `psel` and `penable` cleared the same cycle, FSM in IDLE, next request granted normally.

Source files
------------

// File: rtl/obi_apb_splitter.sv
// OBI target port fanned out to NUM_TARGETS APB4 completers in a contiguous window,
// with per-slot runtime enables, an ACCESS-phase timeout and error responses.
module obi_apb_splitter #(
  parameter int unsigned         NUM_TARGETS    = 5,
  parameter int unsigned         OBI_AW         = 32,
  parameter int unsigned         OBI_DW         = 32,
  parameter int unsigned         OBI_IDW        = 1,
  parameter logic [OBI_AW-1:0]   ADDR_BASE      = 32'h0105_0000,
  parameter int unsigned         SS_SIZE        = 32'h1000,
  parameter int unsigned         TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          obi_req,
  output logic                          obi_gnt,
  output logic                          obi_gntpar,
  input  logic [OBI_AW-1:0]             obi_addr,
  input  logic                          obi_we,
  input  logic [OBI_DW/8-1:0]           obi_be,
  input  logic [OBI_DW-1:0]             obi_wdata,
  input  logic [OBI_IDW-1:0]            obi_aid,
  output logic                          obi_rvalid,
  output logic                          obi_rvalidpar,
  input  logic                          obi_rready,
  output logic [OBI_DW-1:0]             obi_rdata,
  output logic [OBI_IDW-1:0]            obi_rid,
  output logic                          obi_err,
  input  logic [NUM_TARGETS-1:0]        ss_ctrl_icn,
  output logic [NUM_TARGETS-1:0]        apb_psel,
  output logic                          apb_penable,
  output logic                          apb_pwrite,
  output logic [OBI_AW-1:0]             apb_paddr,
  output logic [OBI_DW-1:0]             apb_pwdata,
  output logic [OBI_DW/8-1:0]           apb_pstrb,
  input  logic [NUM_TARGETS*OBI_DW-1:0] apb_prdata,
  input  logic [NUM_TARGETS-1:0]        apb_pready,
  input  logic [NUM_TARGETS-1:0]        apb_pslverr
);

  localparam int unsigned APB_AW   = OBI_AW;
  localparam int unsigned APB_DW   = OBI_DW;
  localparam int unsigned BW       = APB_DW / 8;
  localparam int unsigned IDX_W    = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int unsigned SS_SHIFT = $clog2(SS_SIZE);
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_TARGETS-1:0] psel_d;
  logic                   penable_d, pwrite_d, rvalid_d, err_d;
  logic [APB_AW-1:0]      paddr_d;
  logic [APB_DW-1:0]      pwdata_d, rdata_d;
  logic [BW-1:0]          pstrb_d;
  logic [OBI_IDW-1:0]     rid_d;

  logic [OBI_AW-1:0]      dec_off, dec_slot;
  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_hit, dec_ok;
  logic                   sel_ready, sel_slverr;
  logic [APB_DW-1:0]      sel_rdata;

  // Address decode against the window; the enable is looked up by shift so
  // out-of-range slot numbers never index past the enable vector.
  always_comb begin
    dec_off  = obi_addr - ADDR_BASE;
    dec_slot = dec_off >> SS_SHIFT;
    dec_idx  = dec_slot[IDX_W-1:0];
    dec_hit  = (obi_addr >= ADDR_BASE) && (dec_slot < OBI_AW'(NUM_TARGETS));
    dec_ok   = dec_hit && (|(ss_ctrl_icn & (NUM_TARGETS'(1) << dec_idx)));
  end

  // Completer response mux for the latched slot
  always_comb begin
    sel_ready  = 1'b0;
    sel_slverr = 1'b0;
    sel_rdata  = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready  = apb_pready[i];
        sel_slverr = apb_pslverr[i];
        sel_rdata  = apb_prdata[i*APB_DW +: APB_DW];
      end
    end
  end

  assign obi_gnt    = (state_q == IDLE) && obi_req;
  assign obi_gntpar = ~obi_gnt;

  // Next-state and next-value logic for every registered output
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    psel_d    = apb_psel;
    penable_d = apb_penable;
    pwrite_d  = apb_pwrite;
    paddr_d   = apb_paddr;
    pwdata_d  = apb_pwdata;
    pstrb_d   = apb_pstrb;
    rvalid_d  = obi_rvalid;
    rdata_d   = obi_rdata;
    err_d     = obi_err;
    rid_d     = obi_rid;
    case (state_q)
      IDLE: begin
        if (obi_req) begin
          rid_d = obi_aid;
          if (dec_ok) begin
            state_d  = SETUP;
            idx_d    = dec_idx;
            psel_d   = NUM_TARGETS'(1) << dec_idx;
            pwrite_d = obi_we;
            paddr_d  = obi_addr;
            pwdata_d = obi_wdata;
            pstrb_d  = obi_we ? obi_be : '0;
          end else begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          err_d     = sel_slverr;
          rdata_d   = apb_pwrite ? '0 : sel_rdata;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (obi_rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      apb_psel      <= '0;
      apb_penable   <= 1'b0;
      apb_pwrite    <= 1'b0;
      apb_paddr     <= '0;
      apb_pwdata    <= '0;
      apb_pstrb     <= '0;
      obi_rvalid    <= 1'b0;
      obi_rvalidpar <= 1'b1;
      obi_rdata     <= '0;
      obi_err       <= 1'b0;
      obi_rid       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      apb_psel      <= psel_d;
      apb_penable   <= penable_d;
      apb_pwrite    <= pwrite_d;
      apb_paddr     <= paddr_d;
      apb_pwdata    <= pwdata_d;
      apb_pstrb     <= pstrb_d;
      obi_rvalid    <= rvalid_d;
      obi_rvalidpar <= ~rvalid_d;
      obi_rdata     <= rdata_d;
      obi_err       <= err_d;
      obi_rid       <= rid_d;
    end
  end

endmodule
